// File: rtl/div_pkg.sv
// Shared types and default widths for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_DIVIDEND_W = 16;
  localparam int unsigned DIV_DIVISOR_W  = 8;

  // Bit-counter width for a given dividend width; never less than one bit.
  function automatic int unsigned div_cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_DIVIDEND_W);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   r,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_next_c,
  output logic                 q_bit_c
);

  localparam int unsigned SH_W = DIVISOR_W + 2;

  logic [SH_W-1:0] shifted;
  logic [SH_W-1:0] diff;

  assign shifted  = {r, din};
  assign diff     = shifted - SH_W'(divisor);
  assign q_bit_c  = (shifted >= SH_W'(divisor));
  // Partial remainder stays below the divisor, so the top bit can be dropped.
  assign r_next_c = q_bit_c ? (DIVISOR_W + 1)'(diff) : (DIVISOR_W + 1)'(shifted);

endmodule

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider with valid/ready handshakes on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncate toward zero).
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = div_cnt_w(DIVIDEND_W);
  localparam int unsigned REM_W = DIVISOR_W + 1;

  div_state_e state, state_next;

  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [REM_W-1:0]      rem_q;
  logic [REM_W-1:0]      rem_next;
  logic [CNT_W-1:0]      cnt_q;
  logic                  q_bit;

  logic                  accept_c;
  logic                  take_c;
  logic                  last_c;
  logic                  zero_div_c;
  logic [DIVIDEND_W-1:0] dvd_mag_c;
  logic [DIVISOR_W-1:0]  dvs_mag_c;
  logic [DIVIDEND_W-1:0] quo_mag_c;
  logic [DIVISOR_W-1:0]  rem_mag_c;
  logic [DIVIDEND_W-1:0] quo_fin_c;
  logic [DIVISOR_W-1:0]  rem_fin_c;

  assign accept_c   = in_valid & in_ready;
  assign take_c     = out_valid & out_ready;
  assign zero_div_c = (divisor == '0);
  assign last_c     = (state == CALC) && (cnt_q == '0);
  // Dividend register doubles as the quotient shift register.
  assign quo_mag_c  = DIVIDEND_W'({dvd_q, q_bit});
  assign rem_mag_c  = DIVISOR_W'(rem_next);

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r        (rem_q),
    .din      (dvd_q[DIVIDEND_W-1]),
    .divisor  (dvs_q),
    .r_next_c (rem_next),
    .q_bit_c  (q_bit)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  // Divide magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
  assign dvd_mag_c = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend) : dividend;
  assign dvs_mag_c = divisor[DIVISOR_W-1] ? DIVISOR_W'(-divisor) : divisor;
  assign quo_fin_c = neg_q_q ? DIVIDEND_W'(-quo_mag_c) : quo_mag_c;
  assign rem_fin_c = neg_r_q ? DIVISOR_W'(-rem_mag_c) : rem_mag_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept_c) begin
      neg_q_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      neg_r_q <= dividend[DIVIDEND_W-1];
    end
  end
`else
  assign dvd_mag_c = dividend;
  assign dvs_mag_c = divisor;
  assign quo_fin_c = quo_mag_c;
  assign rem_fin_c = rem_mag_c;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; divide-by-zero skips the iteration entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = zero_div_c ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_next = DONE;
      DONE:    if (take_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if ((state == IDLE) && accept_c) begin
        dvd_q <= dvd_mag_c;
        dvs_q <= dvs_mag_c;
        rem_q <= '0;
        cnt_q <= CNT_W'(DIVIDEND_W - 1);
        if (zero_div_c) begin
          quotient    <= '1;
          remainder   <= dividend[DIVISOR_W-1:0];
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        dvd_q <= quo_mag_c;
        rem_q <= rem_next;
        cnt_q <= cnt_q - CNT_W'(1);
        if (last_c) begin
          quotient    <= quo_fin_c;
          remainder   <= rem_fin_c;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed vector bench for restoring_divider (16/8); define DIV_SIGNED_EN to run the signed table.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  restoring_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present one operand pair for the accepting edge, then scramble the (ignored) operand inputs.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Cycles from the accept cycle until out_valid is seen; capped at 40.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 17}); // -100 / 7
    vecs.push_back('{16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 17}); // wrap case
    vecs.push_back('{16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 17});
    vecs.push_back('{16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 17}); // 100 / -7
    vecs.push_back('{16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0, 17}); // -100 / -7
    vecs.push_back('{16'hFFFB, 8'h09, 16'h0000, 8'hFB, 1'b0, 17}); // -5 / 9
    vecs.push_back('{16'h3F01, 8'h7F, 16'h007F, 8'h00, 1'b0, 17});
    vecs.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1});
`else
    vecs.push_back('{16'h3F01, 8'h7F, 16'h007F, 8'h00, 1'b0, 17});
    vecs.push_back('{16'h3872, 8'h55, 16'h00AA, 8'h00, 1'b0, 17});
    vecs.push_back('{16'd100,  8'd7,  16'd14,   8'd2,  1'b0, 17});
    vecs.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1});
    vecs.push_back('{16'd5,    8'd9,  16'd0,    8'd5,  1'b0, 17});
    vecs.push_back('{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17});
    vecs.push_back('{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17});
    vecs.push_back('{16'hFFFF, 8'h80, 16'h01FF, 8'h7F, 1'b0, 17});
    vecs.push_back('{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 17});
    vecs.push_back('{16'hABCD, 8'hFE, 16'h00AD, 8'h27, 1'b0, 17});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);

    // Table-driven vectors, taken back to back.
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_in_ready_during_done", i), 32'(in_ready), 32'd0);
      take();
      chk($sformatf("v%0d_out_valid_after_take", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_after_take", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure: result held for 10 cycles while a second request is offered.
    start_op(16'h3F01, 8'h7F);
    wait_valid(lat);
    chk("hold_latency", 32'(lat), 32'd17);
    q_hold = 16'h007F;
    r_hold = 8'h00;
    for (int c = 0; c < 10; c++) begin
      dividend = 16'h00FF;
      divisor  = 8'h01;
      in_valid = 1'b1;
      tick();
      chk($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_quotient", c), 32'(quotient), 32'(q_hold));
      chk($sformatf("hold%0d_remainder", c), 32'(remainder), 32'(r_hold));
    end
    in_valid = 1'b0;
    take();
    tick();
    chk("hold_no_second_result", 32'(out_valid), 32'd0);
    chk("hold_idle_in_ready", 32'(in_ready), 32'd1);

    // Reset five cycles into the iteration discards the operation.
    start_op(16'h3F01, 8'h7F);
    for (int c = 0; c < 5; c++) tick();
    chk("midcalc_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midcalc_rst_quotient", 32'(quotient), 32'd0);
    start_op(16'd100, 8'd7);
    wait_valid(lat);
    chk("after_rst_latency", 32'(lat), 32'd17);
    chk("after_rst_quotient", 32'(quotient), 32'd14);
    chk("after_rst_remainder", 32'(remainder), 32'd2);
    take();

    // Reset while a result is waiting in DONE.
    start_op(16'h1234, 8'h00);
    wait_valid(lat);
    chk("done_rst_dbz_latency", 32'(lat), 32'd1);
    chk("done_rst_dbz_flag", 32'(div_by_zero), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_rst_out_valid", 32'(out_valid), 32'd0);
    chk("done_rst_dbz_cleared", 32'(div_by_zero), 32'd0);
    chk("done_rst_remainder", 32'(remainder), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
